instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 8-bit-PC pipeline. Owns the program counter and issues word-addressed reads to instruction memory over a req/ready handshake. Delivers one registered instruction per cycle to the IF/ID pipeline register, together with the incremented PC. Handles hazard-unit stall (with a one-entry skid buffer) and branch redirect (with squash of in-flight reads).

## Interface
- PC_W, 8, PC / address width
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, first fetch address after reset
- NOP_INSTR, 32'hF800_0000, bubble encoding presented when no valid instruction
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous assert, active-low (rst=0 resets), synchronous deassert supplied externally
- stall  in  1  hazard unit: hold outputs, do not advance
- branch_taken  in  1  redirect request from later stage
- branch_target  in  PC_W  redirect address
- imem_req  out  1  read request to instruction memory
- imem_addr  out  PC_W  read word address (= internal pc)
- imem_ready  in  1  memory: imem_rdata valid this cycle, request retired
- imem_rdata  in  INSTR_W  fetched instruction
- outPC  out  PC_W  PC+1 of delivered instruction (IF/ID subtracts 1)
- outInstruction  out  INSTR_W  delivered instruction or NOP_INSTR
- out_valid  out  1  outInstruction is a real fetched instruction

## Operation
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, outPC=0, outInstruction=NOP_INSTR, out_valid=0, skid_valid=0.
- States: IDLE, FETCH, STALLED, DISCARD.
- IDLE: one cycle after reset release, unconditional -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; addr held stable while req=1 and ready=0.
  - ready=1, stall=0, no branch: out <= {pc+1, imem_rdata, valid=1}; pc <= pc+1; stay FETCH (back-to-back).
  - ready=1, stall=1: skid <= {pc+1, imem_rdata}, skid_valid=1; pc <= pc+1; outputs hold; -> STALLED.
  - ready=0, stall=0: out <= {outPC held, NOP_INSTR, valid=0}.
  - ready=0, stall=1: outputs hold; req stays 1 (protocol); stay FETCH.
- STALLED: imem_req=0; outputs hold. When stall=0: if skid_valid, out <= skid, valid=1, skid_valid=0; else bubble; -> FETCH.
- DISCARD: imem_req=1, addr = old pc (unchanged); on ready=1 drop rdata, out <= bubble, -> FETCH at the redirected pc.
- Branch (branch_taken=1, any state except IDLE): highest priority over stall. pc <= branch_target; skid_valid <= 0; out <= bubble (NOP_INSTR, valid=0, outPC held).
  - If a request is outstanding and ready=0 this cycle: -> DISCARD; the target is kept in a redirect register and loaded into pc on exit.
  - If ready=1 this cycle: rdata dropped, -> FETCH.
  - In STALLED: -> FETCH.
- Arithmetic: pc and outPC modulo 2^PC_W. pc=8'hFF delivers outPC=8'h00, next fetch address 8'h00.

## Timing
- Zero-wait memory (ready in the same cycle as req): first imem_req in the 2nd cycle after reset release; first out_valid=1 one cycle later; then 1 instruction/cycle.
- Latency from imem_ready to outputs: 1 cycle (registered).
- Branch to first target fetch: imem_addr=branch_target in the next cycle, unless in DISCARD (then after the old ready).
- Stall deassert to skid delivery: 1 cycle; new request issued in the same cycle as delivery.
- Async reset mid-request: imem_req drops immediately and the response is ignored. Memory must tolerate an abandoned request.
- Branch and stall in the same cycle: branch wins. Stall in the following cycle holds the bubble.

## Test plan
- Reset then zero-wait memory returning rdata=addr+32'h100: outPC sequence 1,2,3…; outInstruction 32'h100,101,…; one per cycle after 3-cycle startup.
- Memory with 2 wait states: imem_addr stable across waits; 2 NOP bubbles (valid=0, outPC held) between instructions.
- Stall asserted for 3 cycles while a response arrives: outputs frozen, req drops after capture; on release the skid instruction appears, then the next address is fetched with no loss or duplicate.
- branch_taken with target=8'h40 during a 3-wait-state request: the old response is discarded; next imem_addr=8'h40; first valid outPC=8'h41.
- PC wrap: RESET_PC=8'hFE gives outPC 8'hFF, 8'h00, 8'h01 and imem_addr 8'hFE, 8'hFF, 8'h00.
- rst pulsed low mid-FETCH with skid full: all outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: word-addressed request/ready handshake between
// the fetch stage (master) and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, delivers one registered
// instruction per cycle with stall skid buffering and branch redirect/squash.
module instruction_fetch #(
    parameter int                 PC_W      = 8,
    parameter int                 INSTR_W   = 32,
    parameter logic [PC_W-1:0]    RESET_PC  = 8'h00,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hF800_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    instruction_fetch_if.master imem,
    output logic [PC_W-1:0]     outPC,
    output logic [INSTR_W-1:0]  outInstruction,
    output logic                out_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALLED = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [PC_W-1:0]    pc_r, pc_s, pc_inc_s;
    logic [PC_W-1:0]    redirect_r, redirect_s;
    logic [PC_W-1:0]    skid_pc_r, skid_pc_s;
    logic [INSTR_W-1:0] skid_instr_r, skid_instr_s;
    logic               skid_valid_r, skid_valid_s;
    logic [PC_W-1:0]    out_pc_r, out_pc_s;
    logic [INSTR_W-1:0] out_instr_r, out_instr_s;
    logic               out_valid_r, out_valid_s;
    logic               req_r, req_s;

    assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

    // Next-state and next-output decode; branch outranks stall in every active state.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        redirect_s   = redirect_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        skid_valid_s = skid_valid_r;
        out_pc_s     = out_pc_r;
        out_instr_s  = out_instr_r;
        out_valid_s  = out_valid_r;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    skid_valid_s = 1'b0;
                    out_instr_s  = NOP_INSTR;
                    out_valid_s  = 1'b0;
                    if (imem.imem_ready) begin
                        pc_s    = branch_target;
                        state_s = FETCH;
                    end else begin
                        // Outstanding read must retire at the old address before redirecting.
                        redirect_s = branch_target;
                        state_s    = DISCARD;
                    end
                end else if (imem.imem_ready) begin
                    pc_s = pc_inc_s;
                    if (stall) begin
                        skid_pc_s    = pc_inc_s;
                        skid_instr_s = imem.imem_rdata;
                        skid_valid_s = 1'b1;
                        state_s      = STALLED;
                    end else begin
                        out_pc_s    = pc_inc_s;
                        out_instr_s = imem.imem_rdata;
                        out_valid_s = 1'b1;
                        state_s     = FETCH;
                    end
                end else if (stall) begin
                    state_s = FETCH;
                end else begin
                    out_instr_s = NOP_INSTR;
                    out_valid_s = 1'b0;
                end
            end
            STALLED: begin
                if (branch_taken) begin
                    pc_s         = branch_target;
                    skid_valid_s = 1'b0;
                    out_instr_s  = NOP_INSTR;
                    out_valid_s  = 1'b0;
                    state_s      = FETCH;
                end else if (!stall) begin
                    if (skid_valid_r) begin
                        out_pc_s    = skid_pc_r;
                        out_instr_s = skid_instr_r;
                        out_valid_s = 1'b1;
                    end else begin
                        out_instr_s = NOP_INSTR;
                        out_valid_s = 1'b0;
                    end
                    skid_valid_s = 1'b0;
                    state_s      = FETCH;
                end else begin
                    state_s = STALLED;
                end
            end
            DISCARD: begin
                if (imem.imem_ready) begin
                    pc_s         = branch_taken ? branch_target : redirect_r;
                    skid_valid_s = 1'b0;
                    out_instr_s  = NOP_INSTR;
                    out_valid_s  = 1'b0;
                    state_s      = FETCH;
                end else if (branch_taken) begin
                    redirect_s   = branch_target;
                    skid_valid_s = 1'b0;
                    out_instr_s  = NOP_INSTR;
                    out_valid_s  = 1'b0;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_s = (state_s == FETCH) || (state_s == DISCARD);
    end

    // State, PC, skid and output registers; reset drops the request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            redirect_r   <= {PC_W{1'b0}};
            skid_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= {INSTR_W{1'b0}};
            skid_valid_r <= 1'b0;
            out_pc_r     <= {PC_W{1'b0}};
            out_instr_r  <= NOP_INSTR;
            out_valid_r  <= 1'b0;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            redirect_r   <= redirect_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
            skid_valid_r <= skid_valid_s;
            out_pc_r     <= out_pc_s;
            out_instr_r  <= out_instr_s;
            out_valid_r  <= out_valid_s;
            req_r        <= req_s;
        end
    end

    assign imem.imem_req   = req_r;
    assign imem.imem_addr  = pc_r;
    assign outPC           = out_pc_r;
    assign outInstruction  = out_instr_r;
    assign out_valid       = out_valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then randomized stall/branch/wait
// traffic, checked against an in-order program-stream reference model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP    = 32'hF800_0000;
    localparam logic [7:0]  RST_PC = 8'h00;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  outPC;
    logic [31:0] outInstruction;
    logic        out_valid;

    int tests, fails, deliveries;
    int wait_cnt, wait_need, wmin, wmax;
    logic [7:0]  exp_addr, p_pc;
    logic [31:0] p_instr;
    logic        p_valid;

    instruction_fetch_if #(.PC_W(8), .INSTR_W(32)) ifc ();

    instruction_fetch #(
        .PC_W(8), .INSTR_W(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem(ifc), .outPC(outPC), .outInstruction(outInstruction),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'h0000_0100 + {24'h000000, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p_pc    = outPC;
        p_instr = outInstruction;
        p_valid = out_valid;
    endtask

    // One clock: memory responds at the falling edge, the model judges after the rising edge.
    task automatic step(input logic st, input logic br, input logic [7:0] tgt);
        logic       rq, rdy;
        logic [7:0] ad;
        @(negedge clk);
        stall = st; branch_taken = br; branch_target = tgt;
        rq  = ifc.imem_req;
        ad  = ifc.imem_addr;
        rdy = rq && (wait_cnt >= wait_need);
        ifc.imem_ready = rdy;
        ifc.imem_rdata = rdy ? mem_word(ad) : $urandom();
        @(posedge clk);
        #1;
        if (rq && rdy) begin
            wait_cnt  = 0;
            wait_need = $urandom_range(wmax, wmin);
        end else if (rq) begin
            wait_cnt++;
        end
        if (br) begin
            chk("branch_valid", {31'd0, out_valid}, 32'd0);
            chk("branch_instr", outInstruction, NOP);
            chk("branch_pc", {24'd0, outPC}, {24'd0, p_pc});
            exp_addr = tgt;
        end else if (st) begin
            chk("hold_valid", {31'd0, out_valid}, {31'd0, p_valid});
            chk("hold_pc", {24'd0, outPC}, {24'd0, p_pc});
            chk("hold_instr", outInstruction, p_instr);
        end else if (out_valid === 1'b1) begin
            chk("deliver_pc", {24'd0, outPC}, {24'd0, exp_addr + 8'd1});
            chk("deliver_instr", outInstruction, mem_word(exp_addr));
            exp_addr = exp_addr + 8'd1;
            deliveries++;
        end else begin
            chk("bubble_instr", outInstruction, NOP);
            chk("bubble_pc", {24'd0, outPC}, {24'd0, p_pc});
        end
        if (rq && !rdy) begin
            chk("wait_req", {31'd0, ifc.imem_req}, 32'd1);
            chk("wait_addr", {24'd0, ifc.imem_addr}, {24'd0, ad});
        end
        snap();
    endtask

    task automatic check_reset();
        chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);
        chk("rst_addr", {24'd0, ifc.imem_addr}, {24'd0, RST_PC});
        chk("rst_pc", {24'd0, outPC}, 32'd0);
        chk("rst_instr", outInstruction, NOP);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle, released just after the next rising edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        #1;
        check_reset();
        stall = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        exp_addr  = RST_PC;
        wait_cnt  = 0;
        wait_need = 0;
        wmin      = 0;
        wmax      = 0;
        snap();
    endtask

    initial begin
        logic [7:0]  h_pc, a_old;
        logic [31:0] h_instr;
        logic        seen, got;
        tests = 0; fails = 0; deliveries = 0;
        wait_cnt = 0; wait_need = 0; wmin = 0; wmax = 0;
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        ifc.imem_ready = 1'b0; ifc.imem_rdata = 32'h0;
        exp_addr = RST_PC;

        #12;
        check_reset();
        snap();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Zero-wait startup and back-to-back delivery.
        step(1'b0, 1'b0, 8'h00);
        chk("first_req", {31'd0, ifc.imem_req}, 32'd1);
        chk("first_addr", {24'd0, ifc.imem_addr}, {24'd0, RST_PC});
        chk("first_valid_low", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 8'h00);
        chk("first_out_valid", {31'd0, out_valid}, 32'd1);
        chk("first_out_pc", {24'd0, outPC}, 32'd1);
        chk("first_out_instr", outInstruction, 32'h0000_0100);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        end

        // Two wait states: two held-PC bubbles between instructions.
        wmin = 2; wmax = 2; wait_need = 2;
        for (int k = 0; k < 2; k++) begin
            h_pc = outPC;
            step(1'b0, 1'b0, 8'h00);
            chk("ws_bubble1", {23'd0, out_valid, outPC}, {23'd0, 1'b0, h_pc});
            step(1'b0, 1'b0, 8'h00);
            chk("ws_bubble2", {23'd0, out_valid, outPC}, {23'd0, 1'b0, h_pc});
            step(1'b0, 1'b0, 8'h00);
            chk("ws_deliver", {23'd0, out_valid, outPC}, {23'd0, 1'b1, h_pc + 8'd1});
        end

        // Three-cycle stall while a response arrives: skid capture then release.
        wmin = 0; wmax = 0; wait_need = 0;
        step(1'b0, 1'b0, 8'h00);
        h_pc = outPC; h_instr = outInstruction;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            chk("stall_req", {31'd0, ifc.imem_req}, 32'd0);
            chk("stall_frozen", {24'd0, outPC}, {24'd0, h_pc});
        end
        step(1'b0, 1'b0, 8'h00);
        chk("skid_pc", {24'd0, outPC}, {24'd0, h_pc + 8'd1});
        chk("skid_req", {31'd0, ifc.imem_req}, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        chk("after_skid_pc", {24'd0, outPC}, {24'd0, h_pc + 8'd2});

        // Branch to 8'h40 during a three-wait-state read.
        wmin = 3; wmax = 3; wait_need = 3;
        step(1'b0, 1'b0, 8'h00);
        a_old = ifc.imem_addr;
        step(1'b0, 1'b1, 8'h40);
        chk("discard_addr", {24'd0, ifc.imem_addr}, {24'd0, a_old});
        chk("discard_req", {31'd0, ifc.imem_req}, 32'd1);
        seen = 1'b0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (!seen && ifc.imem_req === 1'b1 && ifc.imem_addr !== a_old) begin
                seen = 1'b1;
                chk("redirect_addr", {24'd0, ifc.imem_addr}, 32'h40);
            end
            if (out_valid === 1'b1) begin
                got = 1'b1;
                chk("redirect_first_pc", {24'd0, outPC}, 32'h41);
                break;
            end
        end
        chk("redirect_seen", {31'd0, seen}, 32'd1);
        chk("redirect_delivered", {31'd0, got}, 32'd1);

        // PC wrap through 8'hFF.
        wmin = 0; wmax = 0; wait_need = 0;
        step(1'b0, 1'b1, 8'hFE);
        chk("wrap_addr0", {24'd0, ifc.imem_addr}, 32'hFE);
        step(1'b0, 1'b0, 8'h00);
        chk("wrap_pc0", {24'd0, outPC}, 32'hFF);
        chk("wrap_addr1", {24'd0, ifc.imem_addr}, 32'hFF);
        step(1'b0, 1'b0, 8'h00);
        chk("wrap_pc1", {24'd0, outPC}, 32'h00);
        chk("wrap_instr1", outInstruction, 32'h0000_01FF);
        chk("wrap_addr2", {24'd0, ifc.imem_addr}, 32'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("wrap_pc2", {24'd0, outPC}, 32'h01);

        // Reset with the skid buffer full, then with a read outstanding.
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        pulse_reset();
        step(1'b0, 1'b0, 8'h00);
        chk("restart_addr", {24'd0, ifc.imem_addr}, {24'd0, RST_PC});
        step(1'b0, 1'b0, 8'h00);
        chk("restart_pc", {24'd0, outPC}, {24'd0, RST_PC + 8'd1});
        chk("restart_valid", {31'd0, out_valid}, 32'd1);
        wait_need = 5;
        step(1'b0, 1'b0, 8'h00);
        chk("pending_req", {31'd0, ifc.imem_req}, 32'd1);
        pulse_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("restart2_pc", {24'd0, outPC}, {24'd0, RST_PC + 8'd1});

        // Randomized stalls, branches and wait states.
        wmin = 0; wmax = 3;
        deliveries = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0, 8'($urandom()));
        end
        chk("random_liveness", {31'd0, deliveries >= 30}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
